intdiv_iter: RTL and testbench

//  Iterative radix-2 integer divider, the responder on the IEU's MDU divide request interface.

---
 rtl/mdu_pkg.sv | 16 +
 rtl/intdiv_step.sv | 30 +++
 rtl/intdiv_iter.sv | 167 ++++++++++++++++
 tb/tb_intdiv_iter.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: funct3 encodings of the
// divide/remainder family and the iterative divider state type.
package mdu_pkg;

    localparam logic [2:0] FUNCT3_DIV  = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU = 3'b101;
    localparam logic [2:0] FUNCT3_REM  = 3'b110;
    localparam logic [2:0] FUNCT3_REMU = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } divstate_t;

endpackage

// File: rtl/intdiv_step.sv
// One restoring-division step: shift {rem,quot} left by one, try to subtract
// the divisor from the widened partial remainder, keep the difference and set
// the new quotient bit when no borrow occurs.
module intdiv_step #(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quot_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quot_out
);

    logic [XLEN:0] rem_shift;
    logic [XLEN:0] trial;

    // Trial subtraction one bit wider than the datapath so the borrow is explicit
    always_comb begin
        rem_shift = {rem_in, quot_in[XLEN-1]};
        trial     = rem_shift - {1'b0, divisor};
        if (trial[XLEN]) begin
            rem_out  = rem_shift[XLEN-1:0];
            quot_out = {quot_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out  = trial[XLEN-1:0];
            quot_out = {quot_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/intdiv_iter.sv
// Iterative radix-2 divider answering the IEU divide request interface.
// Operands are captured as magnitudes, divided one bit per cycle, then the
// signs are restored and the (optionally 32-bit, sign-extended) result is
// registered into Memory when Execute is not stalled.
module intdiv_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic            IntDivE,
    input  logic [2:0]      Funct3E,
    input  logic            W64E,
    input  logic [XLEN-1:0] ForwardedSrcAE,
    input  logic [XLEN-1:0] ForwardedSrcBE,
    output logic            DivBusyE,
    output logic [XLEN-1:0] DivResultM
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = XLEN'(1) << (XLEN - 1);

    divstate_t state, state_next;

    logic start;
    logic write_result;
    logic step_en;

    logic [CW-1:0]   counter;
    logic [XLEN-1:0] rem_q, quot_q, divisor_q;
    logic            neg_quot_q, neg_rem_q, is_rem_q, is_w_q;

    logic            signed_op, rem_op, w_op;
    logic [XLEN-1:0] a_in, b_in, a_abs, b_abs;
    logic            sign_a, sign_b;
    logic            div_by_zero, overflow, special;

    logic [XLEN-1:0] rem_next, quot_next;
    logic [XLEN-1:0] quot_fix, rem_fix, result_sel, result_final;

    assign signed_op = (Funct3E == FUNCT3_DIV) || (Funct3E == FUNCT3_REM);
    assign rem_op    = (Funct3E == FUNCT3_REM) || (Funct3E == FUNCT3_REMU);

    // W-forms narrow the operands to 32 bits, extended according to signedness
    generate
        if (XLEN == 64) begin : g_wide
            assign w_op = W64E;
            assign a_in = W64E ? {{32{signed_op & ForwardedSrcAE[31]}}, ForwardedSrcAE[31:0]}
                               : ForwardedSrcAE;
            assign b_in = W64E ? {{32{signed_op & ForwardedSrcBE[31]}}, ForwardedSrcBE[31:0]}
                               : ForwardedSrcBE;
        end else begin : g_narrow
            assign w_op = 1'b0;
            assign a_in = ForwardedSrcAE;
            assign b_in = ForwardedSrcBE;
        end
    endgenerate

    assign sign_a      = signed_op & a_in[XLEN-1];
    assign sign_b      = signed_op & b_in[XLEN-1];
    assign a_abs       = sign_a ? -a_in : a_in;
    assign b_abs       = sign_b ? -b_in : b_in;
    assign div_by_zero = (b_in == '0);
    assign overflow    = signed_op && (b_in == '1) &&
                         (w_op ? (a_in[31:0] == 32'h8000_0000) : (a_in == MOST_NEG));
    assign special     = div_by_zero | overflow;

    intdiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in  (rem_q),
        .quot_in (quot_q),
        .divisor (divisor_q),
        .rem_out (rem_next),
        .quot_out(quot_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; a flush always returns the divider to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = special ? DONE : BUSY;
            BUSY:    if (counter == '0) state_next = DONE;
            DONE:    if (!StallE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (FlushE) state_next = IDLE;
    end

    // Control outputs: accept, busy handshake, stepping and result write enables
    always_comb begin
        start        = IntDivE & ~FlushE & (state == IDLE);
        DivBusyE     = IntDivE & ~FlushE & (state != DONE);
        step_en      = (state == BUSY);
        write_result = (state == DONE) & ~StallE & ~FlushE;
    end

    // Operand capture on accept, one restoring step per BUSY cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            counter    <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            divisor_q  <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            is_rem_q   <= 1'b0;
            is_w_q     <= 1'b0;
        end else if (start) begin
            is_rem_q <= rem_op;
            is_w_q   <= w_op;
            if (div_by_zero) begin
                quot_q     <= '1;
                rem_q      <= a_in;
                neg_quot_q <= 1'b0;
                neg_rem_q  <= 1'b0;
                counter    <= '0;
            end else if (overflow) begin
                quot_q     <= a_in;
                rem_q      <= '0;
                neg_quot_q <= 1'b0;
                neg_rem_q  <= 1'b0;
                counter    <= '0;
            end else begin
                quot_q     <= w_op ? (a_abs << (XLEN - 32)) : a_abs;
                rem_q      <= '0;
                divisor_q  <= b_abs;
                neg_quot_q <= sign_a ^ sign_b;
                neg_rem_q  <= sign_a;
                counter    <= w_op ? CW'(31) : CW'(XLEN - 1);
            end
        end else if (step_en) begin
            rem_q  <= rem_next;
            quot_q <= quot_next;
            if (counter != '0) counter <= counter - CW'(1);
        end
    end

    assign quot_fix   = neg_quot_q ? -quot_q : quot_q;
    assign rem_fix    = neg_rem_q  ? -rem_q  : rem_q;
    assign result_sel = is_rem_q ? rem_fix : quot_fix;

    // 32-bit results are sign-extended for every W-form, signed or not
    generate
        if (XLEN == 64) begin : g_wext
            assign result_final = is_w_q ? {{32{result_sel[31]}}, result_sel[31:0]} : result_sel;
        end else begin : g_nowext
            assign result_final = result_sel;
        end
    endgenerate

    // Result register only moves when a finished divide leaves DONE unstalled
    always_ff @(posedge clk) begin
        if (reset)             DivResultM <= '0;
        else if (write_result) DivResultM <= result_final;
    end

endmodule

// File: tb/tb_intdiv_iter.sv
// Directed bench for the iterative divider: latency, special cases, W-forms,
// flush, stall and reset behaviour with hand-computed results.
module tb_intdiv_iter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            reset;
    logic            StallE;
    logic            FlushE;
    logic            IntDivE;
    logic [2:0]      Funct3E;
    logic            W64E;
    logic [XLEN-1:0] ForwardedSrcAE;
    logic [XLEN-1:0] ForwardedSrcBE;
    logic            DivBusyE;
    logic [XLEN-1:0] DivResultM;

    int checks = 0;
    int errors = 0;
    int busy_count;
    logic [63:0] last_result;

    intdiv_iter #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .reset         (reset),
        .StallE        (StallE),
        .FlushE        (FlushE),
        .IntDivE       (IntDivE),
        .Funct3E       (Funct3E),
        .W64E          (W64E),
        .ForwardedSrcAE(ForwardedSrcAE),
        .ForwardedSrcBE(ForwardedSrcBE),
        .DivBusyE      (DivBusyE),
        .DivResultM    (DivResultM)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%h expected 0x%h", tag, observed, expected);
        end
    endtask

    // Present an operation and count busy cycles until the divider reaches DONE
    task automatic applyStimulus(input logic [2:0] f3, input logic w, input logic [63:0] a,
                                 input logic [63:0] b, output int busy);
        @(negedge clk);
        Funct3E        = f3;
        W64E           = w;
        ForwardedSrcAE = a;
        ForwardedSrcBE = b;
        FlushE         = 1'b0;
        StallE         = 1'b0;
        IntDivE        = 1'b1;
        busy = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (!DivBusyE) break;
            busy++;
            @(negedge clk);
        end
    endtask

    task automatic runDiv(input string tag, input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_result, input int exp_busy);
        int busy;
        applyStimulus(f3, w, a, b, busy);
        checkOutput({tag, " busy"}, 64'(busy), 64'(exp_busy));
        IntDivE = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({tag, " result"}, DivResultM, exp_result);
        last_result = exp_result;
    endtask

    initial begin
        reset          = 1'b1;
        StallE         = 1'b0;
        FlushE         = 1'b0;
        IntDivE        = 1'b0;
        Funct3E        = 3'b000;
        W64E           = 1'b0;
        ForwardedSrcAE = '0;
        ForwardedSrcBE = '0;
        last_result    = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset result", DivResultM, 64'h0);
        checkOutput("reset busy", 64'(DivBusyE), 64'h0);
        @(negedge clk);
        reset = 1'b0;

        runDiv("divu 100/7", 3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65);
        runDiv("div -7/2", 3'b100, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        runDiv("rem -7%2", 3'b110, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        runDiv("div 7/-2", 3'b100, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65);
        runDiv("divu 5/0", 3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        runDiv("rem 5%0", 3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1);
        runDiv("div min/-1", 3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1);
        runDiv("rem min/-1", 3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1);
        runDiv("divuw", 3'b101, 1'b1, 64'h0000_0005_0000_000A, 64'd3, 64'd3, 33);
        runDiv("remw -7%2", 3'b110, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33);
        runDiv("remuw", 3'b111, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'h0000_0000_0000_0010, 64'hF, 33);
        runDiv("divw min/-1", 3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1);

        // Stall held for four cycles in DONE must keep the old result
        applyStimulus(3'b101, 1'b0, 64'd100, 64'd10, busy_count);
        checkOutput("stall op busy", 64'(busy_count), 64'd65);
        StallE = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("stall hold result", DivResultM, last_result);
            checkOutput("stall busy low", 64'(DivBusyE), 64'h0);
        end
        @(negedge clk);
        StallE  = 1'b0;
        IntDivE = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stall release result", DivResultM, 64'd10);
        last_result = 64'd10;

        // Flush on the tenth BUSY cycle abandons the divide
        @(negedge clk);
        Funct3E        = 3'b101;
        W64E           = 1'b0;
        ForwardedSrcAE = 64'd1000;
        ForwardedSrcBE = 64'd3;
        IntDivE        = 1'b1;
        for (int k = 0; k < 10; k++) @(negedge clk);
        FlushE = 1'b1;
        #1;
        checkOutput("flush busy low", 64'(DivBusyE), 64'h0);
        @(posedge clk);
        #1;
        checkOutput("flush result kept", DivResultM, last_result);
        @(negedge clk);
        FlushE  = 1'b0;
        IntDivE = 1'b0;
        runDiv("divu 9/3 after flush", 3'b101, 1'b0, 64'd9, 64'd3, 64'd3, 65);

        // Reset in the middle of a divide clears the result and restarts cleanly
        @(negedge clk);
        Funct3E        = 3'b101;
        ForwardedSrcAE = 64'd100;
        ForwardedSrcBE = 64'd7;
        IntDivE        = 1'b1;
        repeat (5) @(negedge clk);
        reset   = 1'b1;
        IntDivE = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset mid-op result", DivResultM, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        runDiv("rem 7%-2 after reset", 3'b110, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
